// File: rtl/contador_boton_param_pkg.sv
// Shared types and helpers for the parametrised button counter.
// Coding/policy selectors, ceil-log2 and binary-to-Gray conversion.
package contador_boton_param_pkg;

   localparam int COD_BIN  = 0;
   localparam int COD_GRAY = 1;
   localparam int POL_SAT  = 0;
   localparam int POL_WRAP = 1;

   // Widest count supported; bin2gray works on this width and callers truncate.
   localparam int NMAX = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic logic [NMAX-1:0] bin2gray(input logic [NMAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/contador_boton_param_antirrebote.sv
// Button front end: two-flop synchroniser, level debouncer and press detect.
// o_paso is high in the cycle whose rising edge makes the stable level go 0 -> 1.
module contador_boton_param_antirrebote
   import contador_boton_param_pkg::*;
#(
   parameter int DEB = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_boton,
   output logic o_estable,
   output logic o_paso
);

   localparam int CW = clog2(DEB) + 1;
   localparam logic [CW-1:0] DEB_M1 = CW'(DEB - 1);

   logic          r_s1;
   logic          r_sync;
   logic          r_estable;
   logic [CW-1:0] r_cnt;
   logic          w_accept;

   // A changed level is accepted once it has been seen DEB consecutive cycles.
   assign w_accept = (r_sync != r_estable) && (r_cnt >= DEB_M1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1      <= 1'b0;
         r_sync    <= 1'b0;
         r_estable <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_s1   <= i_boton;
         r_sync <= r_s1;
         if (r_sync == r_estable) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_estable <= r_sync;
            r_cnt     <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_estable = r_estable;
   assign o_paso    = w_accept && r_sync;

endmodule

// File: rtl/contador_boton_param.sv
// Button-driven N-bit up/down counter, binary or Gray output, wrap or saturate.
// Each debounced press steps the count once; pulso/tc are registered one-cycle pulses.
module contador_boton_param
   import contador_boton_param_pkg::*;
#(
   parameter int N    = 3,
   parameter int MAX  = (1 << N) - 1,
   parameter int DEB  = 4,
   parameter int GRAY = COD_BIN,
   parameter int WRAP = POL_WRAP
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_boton,
   input  logic         i_enable,
   input  logic         i_dir,
   input  logic         i_clear,
   output logic [N-1:0] o_q,
   output logic         o_pulso,
   output logic         o_tc
);

   localparam logic [N-1:0] MAX_B = N'(MAX);

   logic         w_estable;
   logic         w_paso;
   logic         w_press;
   logic [N-1:0] w_b_next;
   logic         w_tc_next;
   logic [N-1:0] r_b;
   logic         r_pulso;
   logic         r_tc;

   contador_boton_param_antirrebote #(
      .DEB(DEB)
   ) u_antirrebote (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_boton  (i_boton),
      .o_estable(w_estable),
      .o_paso   (w_paso)
   );

   // A press can only be taken from the released state.
   assign w_press = w_paso && !w_estable;

   // Bounds are compared before stepping so MAX < 2**N-1 never overflows past MAX.
   always_comb begin
      w_b_next  = r_b;
      w_tc_next = 1'b0;
      if (i_clear) begin
         w_b_next = '0;
      end else if (w_press && i_enable) begin
         if (i_dir) begin
            if (r_b >= MAX_B) begin
               w_tc_next = 1'b1;
               w_b_next  = (WRAP == POL_WRAP) ? '0 : MAX_B;
            end else begin
               w_b_next = r_b + N'(1);
            end
         end else begin
            if (r_b == '0) begin
               w_tc_next = 1'b1;
               w_b_next  = (WRAP == POL_WRAP) ? MAX_B : '0;
            end else begin
               w_b_next = r_b - N'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_b     <= '0;
         r_pulso <= 1'b0;
         r_tc    <= 1'b0;
      end else begin
         r_b     <= w_b_next;
         r_pulso <= w_press;
         r_tc    <= w_tc_next;
      end
   end

   always_comb begin
      o_q = r_b;
      if (GRAY == COD_GRAY) begin
         o_q = N'(bin2gray(NMAX'(r_b)));
      end
   end

   assign o_pulso = r_pulso;
   assign o_tc    = r_tc;

endmodule

// File: doc/contador_boton_param.md
Name: contador_boton_param

Overview:
- Parametrised successor of the team's 3-bit button-driven counter FSM.
- Synchronises and debounces a push-button and detects each press.
- Each accepted press steps an N-bit count up or down, in binary or Gray coding, with wrap or saturate at the bounds.
- Sits between a board button and display/LED logic; replaces the fixed-width single-mode counter.

Parameters:
N, 3, count width in bits (2..16).
MAX, 2**N-1, upper count bound; count range is 0..MAX; MAX must not exceed 2**N-1.
DEB, 4, debounce length in cycles a changed level must persist (>=1).
GRAY, 0, output coding: 0 = binary, 1 = Gray of the binary count.
WRAP, 1, bound policy: 1 = wrap, 0 = saturate.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
boton  input  1  raw asynchronous push-button level, active high.
enable  input  1  1 = accepted presses step the count; 0 = presses ignored.
dir  input  1  1 = up, 0 = down; sampled at the stepping edge.
clear  input  1  synchronous count clear; lower priority than reset.
q  output  N  count image: binary count, or its Gray code when GRAY=1.
pulso  output  1  one-cycle pulse per accepted press, independent of enable.
tc  output  1  one-cycle pulse when a step hits a bound.

Behaviour:
- Reset:
  - Sync flops, stable level, debounce counter, binary count b, pulso and tc all go to 0.
  - q=0 in both codings.
  - Reset mid-debounce discards the partial press.
- Synchroniser: two flops boton -> s1 -> boton_s. No logic between the two flops.
- Debouncer: holds register estable and counter cnt (width clog2(DEB)+1).
  - boton_s == estable: cnt <= 0.
  - boton_s != estable and cnt < DEB-1: cnt <= cnt+1.
  - boton_s != estable and cnt == DEB-1: estable <= boton_s, cnt <= 0.
- Press event: paso is asserted when estable rises 0 -> 1.
  - pulso is registered and high for exactly the cycle after that edge.
  - Release (1 -> 0) produces no event.
  - A level held high produces exactly one press.
- Latency: boton high first sampled at edge E0 -> b and q update at edge E0+DEB+1. pulso and tc are high during the following cycle.
- Step at the paso edge, when enable=1 and clear=0:
  - dir=1, b<MAX: b <= b+1.
  - dir=1, b==MAX: WRAP=1 -> b <= 0; WRAP=0 -> hold. tc=1 in both cases.
  - dir=0, b>0: b <= b-1.
  - dir=0, b==0: WRAP=1 -> b <= MAX; WRAP=0 -> hold. tc=1 in both cases.
- Width rule: no intermediate value may exceed MAX or go below 0. Compare before stepping; never rely on natural N-bit overflow when MAX < 2**N-1.
- clear=1: b <= 0 and tc=0, even when a press coincides (press dropped from the count, pulso still fires).
- enable=0 at the paso edge: b holds and tc=0; pulso still fires.
- Output coding: q = b when GRAY=0; q = b ^ (b>>1) when GRAY=1. q is pure combinational from registered b.
- Illegal b > MAX: unreachable. If forced, the next up step wraps/saturates as at MAX.

Decomposition:
- Shared package holds:
  - function bin2gray(N).
  - function clog2.
  - localparams for coding select (COD_BIN=0, COD_GRAY=1) and bound policy (POL_SAT=0, POL_WRAP=1).
- One sub-module: antirrebote (synchroniser + debouncer + rise detect).
  - Params: DEB.
  - Ports: clk, reset, boton in; estable and paso out.
  - The counter/bound logic stays in the top.

Test Plan:
1. Default params; reset pulse, then boton high 10 cycles -> q 000 -> 001 at E0+5; pulso and tc single pulses as specified, tc=0; one step only while held.
2. Glitch filter, DEB=4: boton high 3 cycles, then low -> no pulso, q unchanged; boton high 4 cycles -> exactly one step.
3. Up wrap, WRAP=1, MAX=5, dir=1: 6 presses -> q 1,2,3,4,5,0; tc high only on the press giving 0. Then dir=0, one press -> q=5, tc pulse.
4. Saturate, WRAP=0, MAX=7: 9 presses up -> q ends 7, tc on presses 8 and 9, q held. Then dir=0, 8 presses -> q=0, tc on the last press only.
5. GRAY=1, N=3, 8 up presses from 0 -> q 001,011,010,110,111,101,100,000; each transition changes exactly one bit.
6. Control edges:
   - enable=0 press -> pulso=1, q held.
   - clear coincident with press -> q=0, tc=0.
   - reset asserted at cycle E0+2 of a press -> no step, all outputs 0.
